// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the core's MEM stage and dmem_responder.
// The core side uses the master modport and the responder uses the slave modport.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Stall-capable RV32I data memory: one request at a time, LATENCY wait states, byte/half/word access.
// Define DMEM_MMIO_EN to map a word-only MMIO register at 0xFFFF_FFF0 onto mmio_out_o.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dmem_responder_if.slave     bus,
  output logic                busy_o,
  output logic [31:0]         mmio_out_o
);

  localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = (LATENCY == 0) ? '0 : CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [2:0]      f3_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q;
  logic            commit;

  logic [31:0] mem_q [2**ADDR_W];

  // In IDLE the operands come straight from the bus so LATENCY=0 can commit on the accept edge.
  logic              op_we;
  logic [31:0]       op_addr, op_wdata;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word, new_word, load_data;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              oor, mis, f3_bad, acc_err, is_mmio;
  logic [31:0]       mmio_rd;

  assign op_we    = (state_q == StIdle) ? bus.req_we     : we_q;
  assign op_addr  = (state_q == StIdle) ? bus.req_addr   : addr_q;
  assign op_wdata = (state_q == StIdle) ? bus.req_wdata  : wdata_q;
  assign op_f3    = (state_q == StIdle) ? bus.req_funct3 : f3_q;
  assign word_idx = op_addr[ADDR_W+1:2];
  assign old_word = mem_q[word_idx];
  assign lane_b   = old_word[{op_addr[1:0], 3'b000} +: 8];
  assign lane_h   = old_word[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    oor    = (op_addr >> (ADDR_W + 2)) != 32'd0;
    mis    = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
             ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    f3_bad = op_we ? (op_f3 > 3'd2) : ((op_f3 == 3'd3) || (op_f3[2:1] == 2'b11));
    acc_err = oor | mis | f3_bad;
    is_mmio = 1'b0;
`ifdef DMEM_MMIO_EN
    if (op_addr == 32'hFFFF_FFF0) begin
      is_mmio = 1'b1;
      acc_err = (op_f3 != 3'd2);
    end
`endif
  end

  always_comb begin
    load_data = '0;
    case (op_f3)
      3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_data = {{16{lane_h[15]}}, lane_h};
      3'd2:    load_data = is_mmio ? mmio_rd : old_word;
      3'd4:    load_data = {24'd0, lane_b};
      3'd5:    load_data = {16'd0, lane_h};
      default: load_data = '0;
    endcase
    new_word = old_word;
    case (op_f3)
      3'd0:    new_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      3'd1:    new_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      3'd2:    new_word = op_wdata;
      default: new_word = old_word;
    endcase
    rdata_d = (op_we || acc_err) ? 32'd0 : load_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= acc_err;
      end
    end
  end

  // Array is deliberately not reset; writes only happen on the commit edge.
  always_ff @(posedge clk_i) begin
    if (commit && op_we && !acc_err && !is_mmio) mem_q[word_idx] <= new_word;
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mmio_q <= '0;
    end else if (commit && op_we && !acc_err && is_mmio) begin
      mmio_q <= op_wdata;
    end
  end
  assign mmio_rd    = mmio_q;
  assign mmio_out_o = mmio_q;
`else
  assign mmio_rd    = '0;
  assign mmio_out_o = '0;
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a negedge
// monitor pops and compares on each response handshake and checks accept-to-response latency.
module tb_dmem_responder;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned LATENCY = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [31:0] mmio_out;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .mmio_out_o (mmio_out)
  );

  always #5 clk = ~clk;

  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rsp_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: latency on response rise, scoreboard compare on handshake.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.rsp_valid && !prev_valid)
          check("latency", 32'(cyc - acc_cyc), 32'(LATENCY + 1));
        prev_valid = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            fail_timeout("unexpected_rsp");
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          end
          rsp_cnt++;
        end
      end
    end
  end

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b1;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
  endtask

  // Issue one request from posedge+1; optionally wait for its response to be popped.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                        input bit wait_rsp);
    int   start;
    bit   ok;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
      if (!ok) @(posedge clk);
    end
    if (!ok) begin
      fail_timeout("req_accept");
      drive_idle();
      return;
    end
    @(posedge clk);
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    #1;
    drive_idle();
    if (wait_rsp) begin
      start = rsp_cnt;
      for (int i = 0; i < 30 && rsp_cnt == start; i++) @(posedge clk);
      if (rsp_cnt == start) fail_timeout("rsp_wait");
      #1;
    end
  endtask

  initial begin
    int ok;
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_idle();
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mmio", mmio_out, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word, sub-word loads, sub-word stores
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_req(1'b0, 32'h13, 32'h0, 3'd0, 32'hFFFF_FFDE, 1'b0, 1'b1);
    do_req(1'b0, 32'h13, 32'h0, 3'd4, 32'h0000_00DE, 1'b0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd1, 32'hFFFF_BEEF, 1'b0, 1'b1);
    do_req(1'b0, 32'h12, 32'h0, 3'd5, 32'h0000_DEAD, 1'b0, 1'b1);
    do_req(1'b1, 32'h11, 32'hFFFF_FF55, 3'd0, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD_55EF, 1'b0, 1'b1);
    do_req(1'b1, 32'h12, 32'hABCD_1234, 3'd1, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h1234_55EF, 1'b0, 1'b1);

    // Errors: misaligned, out of range, illegal funct3
    do_req(1'b0, 32'h11, 32'h0, 3'd2, 32'h0, 1'b1, 1'b1);
    do_req(1'b1, 32'h13, 32'hFFFF_FFFF, 3'd1, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h1234_55EF, 1'b0, 1'b1);
    do_req(1'b0, 32'h1000, 32'h0, 3'd2, 32'h0, 1'b1, 1'b1);
    do_req(1'b1, 32'h1010, 32'h0BAD_0BAD, 3'd2, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd6, 32'h0, 1'b1, 1'b1);
    do_req(1'b1, 32'h10, 32'h0, 3'd4, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h1234_55EF, 1'b0, 1'b1);

    // Response back-pressure: outputs hold and new requests are ignored
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h1234_55EF, 1'b0, 1'b0);
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      @(negedge clk);
      ok = int'(bus.rsp_valid);
    end
    if (ok == 0) fail_timeout("stall_rsp_valid");
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_rdata", bus.rsp_rdata, 32'h1234_55EF);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    drive_idle();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_req_ready", 32'(bus.req_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h1234_55EF, 1'b0, 1'b1);

    // Reset during WAIT drops an uncommitted store
    do_req(1'b1, 32'h20, 32'h1111_2222, 3'd2, 32'h0, 1'b0, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hCAFE_F00D;
    bus.req_funct3 = 3'd2;
    @(posedge clk); #1;
    drive_idle();
    check("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdata", bus.rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 3'd2, 32'h1111_2222, 1'b0, 1'b1);

    // MMIO address
`ifdef DMEM_MMIO_EN
    do_req(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 3'd2, 32'h0, 1'b0, 1'b1);
    check("mmio_out", mmio_out, 32'h0000_00A5);
    do_req(1'b0, 32'hFFFF_FFF0, 32'h0, 3'd2, 32'h0000_00A5, 1'b0, 1'b1);
    do_req(1'b1, 32'hFFFF_FFF0, 32'h0000_0077, 3'd0, 32'h0, 1'b1, 1'b1);
    check("mmio_out_byte", mmio_out, 32'h0000_00A5);
`else
    do_req(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 3'd2, 32'h0, 1'b1, 1'b1);
    check("mmio_out", mmio_out, 32'h0);
    do_req(1'b0, 32'hFFFF_FFF0, 32'h0, 3'd2, 32'h0, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
